// File: rtl/l2_access_ctrl.sv
// l2_access_ctrl
// Turns one 64-bit L2 read/write request into two sequential 32-bit beats
// on a word-wide memory port, with alignment checking, error capture and a
// per-beat wait timeout.
//
// Ports
//   CLK, RST          clock, asynchronous active-high reset
//   l2REN / l2WEN     read / write request (held by requester until ACCESS/ERROR)
//   l2addr, l2store   8-byte aligned byte address, 64-bit write data
//   l2load            64-bit read data (holds between read captures)
//   l2state           FREE=0, BUSY=1, ACCESS=2, ERROR=3
//   mem_ren/mem_wen   memory read/write strobes
//   mem_addr          byte address of the current beat (base, then base+4)
//   mem_wdata         write data of the current beat (low word, then high word)
//   mem_rdata         read data, valid with mem_ready
//   mem_ready         single-cycle beat completion
//   mem_error         beat failure, sampled alongside mem_ready
module l2_access_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        l2REN,
  input  logic        l2WEN,
  input  logic [31:0] l2addr,
  input  logic [63:0] l2store,
  output logic [63:0] l2load,
  output logic [1:0]  l2state,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  input  logic        mem_error
);

  typedef enum logic [1:0] {
    L2_FREE   = 2'd0,
    L2_BUSY   = 2'd1,
    L2_ACCESS = 2'd2,
    L2_ERROR  = 2'd3
  } l2_state_t;

  typedef enum logic [2:0] {
    S_IDLE, S_BEAT0, S_BEAT1, S_DONE, S_ERR
  } state_t;

  localparam logic [9:0] LP_TMO = 10'(TIMEOUT);

  state_t      r_state, w_next;
  logic [31:0] r_base;
  logic [63:0] r_store;
  logic        r_op;      // 1 = write
  logic [9:0]  r_cnt;
  logic [63:0] r_load;

  logic w_req, w_illegal, w_stall, w_tmo, w_beat, w_ok;

  assign w_req     = l2REN | l2WEN;
  assign w_illegal = (l2REN & l2WEN) | (l2addr[2:0] != 3'd0);
  assign w_beat    = (r_state == S_BEAT0) | (r_state == S_BEAT1);
  assign w_stall   = ~mem_ready & ~mem_error;
  assign w_tmo     = w_stall & (r_cnt == LP_TMO);
  // error wins over ready when both arrive in the same cycle
  assign w_ok      = mem_ready & ~mem_error;

  // state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req) w_next = w_illegal ? S_ERR : S_BEAT0;
      end
      S_BEAT0: begin
        if (mem_error)      w_next = S_ERR;
        else if (mem_ready) w_next = S_BEAT1;
        else if (w_tmo)     w_next = S_ERR;
      end
      S_BEAT1: begin
        if (mem_error)      w_next = S_ERR;
        else if (mem_ready) w_next = S_DONE;
        else if (w_tmo)     w_next = S_ERR;
      end
      S_DONE:  w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // request latch, beat counter and read capture
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_base  <= '0;
      r_store <= '0;
      r_op    <= 1'b0;
      r_cnt   <= '0;
      r_load  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_req && !w_illegal) begin
            r_base  <= l2addr;
            r_store <= l2store;
            r_op    <= l2WEN;
          end
        end
        S_BEAT0: begin
          if (w_ok) begin
            r_cnt <= '0;
            if (!r_op) r_load[31:0] <= mem_rdata;
          end else if (w_stall) begin
            r_cnt <= r_cnt + 10'd1;
          end
        end
        S_BEAT1: begin
          if (w_ok) begin
            if (!r_op) r_load[63:32] <= mem_rdata;
          end else if (w_stall) begin
            r_cnt <= r_cnt + 10'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // outputs decoded from registered state only
  always_comb begin
    l2state   = L2_FREE;
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      S_BEAT0: begin
        l2state   = L2_BUSY;
        mem_addr  = r_base;
        mem_wdata = r_store[31:0];
      end
      S_BEAT1: begin
        l2state   = L2_BUSY;
        mem_addr  = r_base + 32'd4;   // wraps modulo 2^32
        mem_wdata = r_store[63:32];
      end
      S_DONE:  l2state = L2_ACCESS;
      S_ERR:   l2state = L2_ERROR;
      default: l2state = L2_FREE;
    endcase
    if (w_beat) begin
      mem_ren = ~r_op;
      mem_wen = r_op;
    end
  end

  assign l2load = r_load;

endmodule
